apple_1_pia_fifo: RTL and testbench

//  Parametrised Apple-1 PIA (6821 subset) at $D010-$D013 between the 6502 core and the SystemC/FPGA terminal.
//  - Buffers keyboard and display characters in FIFOs of configurable depth, so the host and CPU are decoupled.
//  - Host side uses 4-phase rdy/ack handshakes. CPU side keeps the WozMon register map and polling semantics.
//  - Sits beside ROM/RAM in apple_1_WozMon_PIA; the top muxes pia_DI onto the CPU DI whenever pia_sel=1.

---
 rtl/apple_1_pia_fifo_pkg.sv | 30 +++
 rtl/apple_1_pia_fifo_sync.sv | 65 ++++++
 rtl/apple_1_pia_fifo.sv | 266 ++++++++++++++++++++++++++
 tb/tb_apple_1_pia_fifo.sv | 339 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/apple_1_pia_fifo_pkg.sv
// Shared definitions for the Apple-1 PIA block: register offsets, control
// register bit positions, handshake FSM encodings and the address decode.
package apple_1_pia_fifo_pkg;

  // Register offsets inside the 4-byte window (AB[1:0])
  localparam logic [1:0] OFF_KBD   = 2'd0;
  localparam logic [1:0] OFF_KBDCR = 2'd1;
  localparam logic [1:0] OFF_DSP   = 2'd2;
  localparam logic [1:0] OFF_DSPCR = 2'd3;

  // CR bit 2 selects the data register instead of the (emulated) DDR
  localparam int CR_ORSEL = 2;

  typedef enum logic {
    K_IDLE = 1'b0,
    K_HOLD = 1'b1
  } kbd_state_t;

  typedef enum logic [1:0] {
    D_IDLE = 2'd0,
    D_WAIT = 2'd1,
    D_REL  = 2'd2
  } dsp_state_t;

  // Upper 14 address bits select the register window
  function automatic logic addr_hit(input logic [15:0] ab, input logic [15:0] base);
    return (ab[15:2] == base[15:2]);
  endfunction

endpackage

// File: rtl/apple_1_pia_fifo_sync.sv
// Small synchronous FIFO with a combinational head. A push and a pop in the
// same cycle both take effect, even when the FIFO is full; a pop on empty is
// ignored. DEPTH must be a power of two so the pointers wrap naturally.
module pia_sync_fifo #(
  parameter int WIDTH = 7,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] C_FULL = DEPTH[AW:0];

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_push;
  logic             w_pop;

  assign w_pop  = pop & (r_count != {(AW+1){1'b0}});
  assign w_push = push & ((r_count != C_FULL) | w_pop);

  assign dout  = r_mem[r_rd_ptr];
  assign empty = (r_count == {(AW+1){1'b0}});
  assign full  = (r_count == C_FULL);
  assign count = r_count;

  // Storage array: written at the tail on an accepted push
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= din;
    end
  end

  // Pointer and occupancy bookkeeping
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= {AW{1'b0}};
      r_rd_ptr <= {AW{1'b0}};
      r_count  <= {(AW+1){1'b0}};
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/apple_1_pia_fifo.sv
// Apple-1 PIA (6821 subset) with keyboard and display FIFOs. The CPU side keeps
// the WozMon register map and polling behaviour; the host side moves characters
// with 4-phase rdy/ack handshakes.
module apple_1_pia_fifo
  import apple_1_pia_fifo_pkg::*;
#(
  parameter logic [15:0] BASE_ADDR = 16'hD010,
  parameter int          KBD_DEPTH = 4,
  parameter int          DSP_DEPTH = 4,
  parameter int          CHAR_W    = 7
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [15:0]       AB,
  input  logic [7:0]        DO,
  input  logic              WE,
  input  logic              RDY,
  output logic [7:0]        pia_DI,
  output logic              pia_sel,
  input  logic              kbd_rdy,
  input  logic [CHAR_W-1:0] kbd_data,
  output logic              kbd_ack,
  output logic              dsp_rdy,
  output logic [CHAR_W-1:0] dsp_data,
  input  logic              dsp_ack
);

  localparam int KAW = $clog2(KBD_DEPTH);
  localparam int DAW = $clog2(DSP_DEPTH);
  localparam logic [DAW:0] C_DSP_FULL = DSP_DEPTH[DAW:0];

  // CPU access decode
  logic        w_rd;
  logic        w_wr;
  logic [1:0]  w_off;
  logic [7:0]  w_rd_data;
  logic        w_unused_do;

  // Keyboard path
  logic              w_kbd_push;
  logic              w_kbd_pop;
  logic [CHAR_W-1:0] w_kbd_head;
  logic              w_kbd_empty;
  logic              w_kbd_full;
  logic [KAW:0]      w_kbd_count;
  kbd_state_t        r_kst;
  kbd_state_t        w_kst_nxt;
  logic              r_kbd_ack;
  logic              w_kbd_ack_nxt;
  logic [CHAR_W-1:0] r_kbd_last;

  // Display path
  logic              w_dsp_req;
  logic              w_dsp_push;
  logic              w_dsp_drop;
  logic              w_dsp_pop;
  logic [CHAR_W-1:0] w_dsp_head;
  logic              w_dsp_empty;
  logic              w_dsp_full;
  logic [DAW:0]      w_dsp_count;
  dsp_state_t        r_dst;
  dsp_state_t        w_dst_nxt;
  logic              r_dsp_rdy;
  logic              w_dsp_rdy_nxt;
  logic [CHAR_W-1:0] r_dsp_data;
  logic [CHAR_W-1:0] w_dsp_data_nxt;

  // Control registers and read port
  logic [5:0] r_kbdcr;
  logic [5:0] r_dspcr;
  logic       r_ovf;
  logic [7:0] r_pia_di;
  logic       r_pia_sel;

  assign w_off       = AB[1:0];
  assign w_rd        = addr_hit(AB, BASE_ADDR) & RDY & ~WE;
  assign w_wr        = addr_hit(AB, BASE_ADDR) & RDY & WE;
  // DO bit 7 has no storage anywhere in this register set
  assign w_unused_do = DO[7];

  // A DSP write only reaches the FIFO with the data register selected; when full
  // it still lands if the display FSM frees a slot on the same edge.
  assign w_dsp_req  = w_wr & (w_off == OFF_DSP) & r_dspcr[CR_ORSEL];
  assign w_dsp_push = w_dsp_req & (~w_dsp_full | w_dsp_pop);
  assign w_dsp_drop = w_dsp_req & w_dsp_full & ~w_dsp_pop;

  assign pia_DI   = r_pia_di;
  assign pia_sel  = r_pia_sel;
  assign kbd_ack  = r_kbd_ack;
  assign dsp_rdy  = r_dsp_rdy;
  assign dsp_data = r_dsp_data;

  pia_sync_fifo #(.WIDTH(CHAR_W), .DEPTH(KBD_DEPTH)) u_kbd_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (w_kbd_push),
    .din   (kbd_data),
    .pop   (w_kbd_pop),
    .dout  (w_kbd_head),
    .empty (w_kbd_empty),
    .full  (w_kbd_full),
    .count (w_kbd_count)
  );

  pia_sync_fifo #(.WIDTH(CHAR_W), .DEPTH(DSP_DEPTH)) u_dsp_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (w_dsp_push),
    .din   (DO[CHAR_W-1:0]),
    .pop   (w_dsp_pop),
    .dout  (w_dsp_head),
    .empty (w_dsp_empty),
    .full  (w_dsp_full),
    .count (w_dsp_count)
  );

  // Read data mux; a KBD read with a character waiting also pops it
  always_comb begin
    w_rd_data = 8'h00;
    w_kbd_pop = 1'b0;
    case (w_off)
      OFF_KBD: begin
        if (r_kbdcr[CR_ORSEL] && !w_kbd_empty) begin
          w_rd_data = 8'h80 | 8'(w_kbd_head);
          w_kbd_pop = w_rd;
        end else begin
          w_rd_data = 8'(r_kbd_last);
        end
      end
      OFF_KBDCR: w_rd_data = {(w_kbd_count != {(KAW+1){1'b0}}), 1'b0, r_kbdcr};
      OFF_DSP:   w_rd_data = {(w_dsp_count == C_DSP_FULL), 7'b000_0000};
      OFF_DSPCR: w_rd_data = {r_ovf, 1'b0, r_dspcr};
      default:   w_rd_data = 8'h00;
    endcase
  end

  // Registered read port: data and select follow a read cycle by one clock
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pia_di  <= 8'h00;
      r_pia_sel <= 1'b0;
    end else begin
      r_pia_sel <= w_rd;
      if (w_rd) begin
        r_pia_di <= w_rd_data;
      end
    end
  end

  // Control registers, display overflow flag and last keyboard character
  always_ff @(posedge clk) begin
    if (reset) begin
      r_kbdcr    <= 6'd0;
      r_dspcr    <= 6'd0;
      r_ovf      <= 1'b0;
      r_kbd_last <= {CHAR_W{1'b0}};
    end else begin
      if (w_wr && (w_off == OFF_KBDCR)) begin
        r_kbdcr <= DO[5:0];
      end
      if (w_wr && (w_off == OFF_DSPCR)) begin
        r_dspcr <= DO[5:0];
        r_ovf   <= 1'b0;
      end else if (w_dsp_drop) begin
        r_ovf <= 1'b1;
      end
      if (w_kbd_pop) begin
        r_kbd_last <= w_kbd_head;
      end
    end
  end

  // Keyboard handshake: next state, ack and FIFO push
  always_comb begin
    w_kst_nxt     = r_kst;
    w_kbd_ack_nxt = r_kbd_ack;
    w_kbd_push    = 1'b0;
    case (r_kst)
      K_IDLE: begin
        if (kbd_rdy && !w_kbd_full) begin
          w_kbd_push    = 1'b1;
          w_kbd_ack_nxt = 1'b1;
          w_kst_nxt     = K_HOLD;
        end else begin
          w_kbd_ack_nxt = 1'b0;
        end
      end
      K_HOLD: begin
        if (!kbd_rdy) begin
          w_kbd_ack_nxt = 1'b0;
          w_kst_nxt     = K_IDLE;
        end else begin
          w_kbd_ack_nxt = 1'b1;
        end
      end
      default: begin
        w_kbd_ack_nxt = 1'b0;
        w_kst_nxt     = K_IDLE;
      end
    endcase
  end

  // Keyboard handshake state and ack register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_kst     <= K_IDLE;
      r_kbd_ack <= 1'b0;
    end else begin
      r_kst     <= w_kst_nxt;
      r_kbd_ack <= w_kbd_ack_nxt;
    end
  end

  // Display handshake: next state, rdy/data and FIFO pop
  always_comb begin
    w_dst_nxt      = r_dst;
    w_dsp_rdy_nxt  = r_dsp_rdy;
    w_dsp_data_nxt = r_dsp_data;
    w_dsp_pop      = 1'b0;
    case (r_dst)
      D_IDLE: begin
        if (!w_dsp_empty) begin
          w_dsp_data_nxt = w_dsp_head;
          w_dsp_pop      = 1'b1;
          w_dsp_rdy_nxt  = 1'b1;
          w_dst_nxt      = D_WAIT;
        end else begin
          w_dsp_rdy_nxt = 1'b0;
        end
      end
      D_WAIT: begin
        if (dsp_ack) begin
          w_dsp_rdy_nxt = 1'b0;
          w_dst_nxt     = D_REL;
        end else begin
          w_dsp_rdy_nxt = 1'b1;
        end
      end
      D_REL: begin
        if (!dsp_ack) begin
          w_dst_nxt = D_IDLE;
        end else begin
          w_dst_nxt = D_REL;
        end
      end
      default: begin
        w_dsp_rdy_nxt = 1'b0;
        w_dst_nxt     = D_IDLE;
      end
    endcase
  end

  // Display handshake state, rdy and data registers
  always_ff @(posedge clk) begin
    if (reset) begin
      r_dst      <= D_IDLE;
      r_dsp_rdy  <= 1'b0;
      r_dsp_data <= {CHAR_W{1'b0}};
    end else begin
      r_dst      <= w_dst_nxt;
      r_dsp_rdy  <= w_dsp_rdy_nxt;
      r_dsp_data <= w_dsp_data_nxt;
    end
  end

endmodule

// File: tb/tb_apple_1_pia_fifo.sv
// Self-checking bench for apple_1_pia_fifo: CPU register accesses, a keyboard
// host driven by tasks and a background display host, checked against queues.
module tb_apple_1_pia_fifo;

  localparam logic [15:0] BASE = 16'hD010;
  localparam int KD = 4;
  localparam int DD = 4;

  logic        clk;
  logic        reset;
  logic [15:0] AB;
  logic [7:0]  DO;
  logic        WE;
  logic        RDY;
  logic [7:0]  pia_DI;
  logic        pia_sel;
  logic        kbd_rdy;
  logic [6:0]  kbd_data;
  logic        kbd_ack;
  logic        dsp_rdy;
  logic [6:0]  dsp_data;
  logic        dsp_ack;

  int nvec = 0;
  int nerr = 0;

  // display host state
  bit         host_stall = 1'b1;
  int         ack_delay  = 0;
  int         wait_cnt   = 0;
  int         rdy_pulses = 0;
  logic       prev_rdy   = 1'b0;
  logic [6:0] got[$];

  apple_1_pia_fifo #(.BASE_ADDR(BASE), .KBD_DEPTH(KD), .DSP_DEPTH(DD), .CHAR_W(7)) dut (
    .clk(clk), .reset(reset), .AB(AB), .DO(DO), .WE(WE), .RDY(RDY),
    .pia_DI(pia_DI), .pia_sel(pia_sel),
    .kbd_rdy(kbd_rdy), .kbd_data(kbd_data), .kbd_ack(kbd_ack),
    .dsp_rdy(dsp_rdy), .dsp_data(dsp_data), .dsp_ack(dsp_ack)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Display host: acks each character after ack_delay cycles unless stalled
  initial begin
    dsp_ack = 1'b0;
    forever begin
      @(negedge clk);
      if (dsp_rdy && !prev_rdy) rdy_pulses++;
      prev_rdy = dsp_rdy;
      if (!dsp_ack) begin
        if (dsp_rdy && !host_stall) begin
          if (wait_cnt >= ack_delay) begin
            got.push_back(dsp_data);
            dsp_ack  = 1'b1;
            wait_cnt = 0;
          end else begin
            wait_cnt++;
          end
        end
      end else if (!dsp_rdy) begin
        dsp_ack = 1'b0;
      end
    end
  end

  task automatic cpu_write(input logic [1:0] off, input logic [7:0] d);
    @(negedge clk);
    AB = BASE | {14'd0, off}; DO = d; WE = 1'b1; RDY = 1'b1;
    @(negedge clk);
    AB = 16'h0000; DO = 8'h00; WE = 1'b0; RDY = 1'b0;
  endtask

  task automatic cpu_read(input logic [1:0] off, output logic [7:0] d, output logic sel);
    @(negedge clk);
    AB = BASE | {14'd0, off}; WE = 1'b0; RDY = 1'b1;
    @(negedge clk);
    d = pia_DI; sel = pia_sel;
    AB = 16'h0000; RDY = 1'b0;
  endtask

  task automatic kbd_send(input logic [6:0] c, output bit ok);
    kbd_data = c; kbd_rdy = 1'b1; ok = 1'b0;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      if (kbd_ack) ok = 1'b1;
    end
    kbd_rdy = 1'b0;
    for (int i = 0; i < 50 && kbd_ack; i++) @(negedge clk);
  endtask

  task automatic wait_got(input int n, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 400 && !ok; i++) begin
      @(negedge clk);
      if (got.size() >= n) ok = 1'b1;
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; AB = 16'h0000; DO = 8'h00; WE = 1'b0; RDY = 1'b0;
    kbd_rdy = 1'b0; kbd_data = 7'h00;
    repeat (3) @(negedge clk);
    nvec++;
    if ({pia_DI, pia_sel, kbd_ack, dsp_rdy, dsp_data} !== 18'd0) begin
      nerr++;
      $display("FAIL reset_outputs: got DI=%h sel=%b ack=%b rdy=%b data=%h, want all 0",
               pia_DI, pia_sel, kbd_ack, dsp_rdy, dsp_data);
    end
    reset = 1'b0;
  endtask

  task automatic test_init;
    logic [7:0] d; logic s; bit seen;
    cpu_write(2'd2, 8'h7F);
    cpu_write(2'd1, 8'hA7);
    cpu_write(2'd3, 8'hA7);
    seen = 1'b0;
    repeat (6) begin @(negedge clk); if (dsp_rdy) seen = 1'b1; end
    nvec++;
    if (seen !== 1'b0) begin nerr++; $display("FAIL init_no_dsp_rdy: got rdy seen=%b want 0", seen); end
    cpu_read(2'd3, d, s); nvec++;
    if ({s, d} !== {1'b1, 8'h27}) begin nerr++; $display("FAIL init_dspcr: got sel=%b %h want 1 27", s, d); end
    cpu_read(2'd1, d, s); nvec++;
    if ({s, d} !== {1'b1, 8'h27}) begin nerr++; $display("FAIL init_kbdcr: got sel=%b %h want 1 27", s, d); end
    cpu_read(2'd2, d, s); nvec++;
    if ({s, d} !== {1'b1, 8'h00}) begin nerr++; $display("FAIL init_dsp: got sel=%b %h want 1 00", s, d); end
    @(negedge clk); nvec++;
    if (pia_sel !== 1'b0) begin nerr++; $display("FAIL idle_sel: got %b want 0", pia_sel); end
  endtask

  task automatic test_kbd_single;
    logic [7:0] d; logic s; bit ok;
    kbd_send(7'h41, ok); nvec++;
    if (!ok) begin nerr++; $display("FAIL kbd1_ack: got no ack want ack"); end
    cpu_read(2'd1, d, s); nvec++;
    if (d !== 8'hA7) begin nerr++; $display("FAIL kbd1_cr_full: got %h want a7", d); end
    cpu_read(2'd0, d, s); nvec++;
    if (d !== 8'hC1) begin nerr++; $display("FAIL kbd1_data: got %h want c1", d); end
    cpu_read(2'd1, d, s); nvec++;
    if (d !== 8'h27) begin nerr++; $display("FAIL kbd1_cr_empty: got %h want 27", d); end
    cpu_read(2'd0, d, s); nvec++;
    if (d !== 8'h41) begin nerr++; $display("FAIL kbd1_last: got %h want 41", d); end
  endtask

  task automatic test_kbd_backpressure;
    logic [7:0] d; logic s; bit ok; bit seen;
    logic [6:0] q[$];
    for (int i = 0; i < KD; i++) begin
      q.push_back(7'h31 + 7'(i));
      kbd_send(7'h31 + 7'(i), ok); nvec++;
      if (!ok) begin nerr++; $display("FAIL bp_ack%0d: got no ack want ack", i); end
    end
    q.push_back(7'h35);
    kbd_data = 7'h35; kbd_rdy = 1'b1; seen = 1'b0;
    repeat (20) begin @(negedge clk); if (kbd_ack) seen = 1'b1; end
    nvec++;
    if (seen) begin nerr++; $display("FAIL bp_held: got ack while full want none"); end
    cpu_read(2'd0, d, s); nvec++;
    if (d !== {1'b1, q.pop_front()}) begin nerr++; $display("FAIL bp_first: got %h want b1", d); end
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin @(negedge clk); if (kbd_ack) ok = 1'b1; end
    nvec++;
    if (!ok) begin nerr++; $display("FAIL bp_late_ack: got no ack want ack"); end
    kbd_rdy = 1'b0;
    for (int i = 0; i < 50 && kbd_ack; i++) @(negedge clk);
    while (q.size() > 0) begin
      logic [7:0] e;
      e = {1'b1, q.pop_front()};
      cpu_read(2'd0, d, s); nvec++;
      if (d !== e) begin nerr++; $display("FAIL bp_order: got %h want %h", d, e); end
    end
    cpu_read(2'd1, d, s); nvec++;
    if (d !== 8'h27) begin nerr++; $display("FAIL bp_empty: got %h want 27", d); end
  endtask

  task automatic test_kbd_random;
    logic [7:0] d; logic s; bit ok;
    logic [6:0] q[$]; logic [6:0] c; logic [6:0] last;
    for (int r = 0; r < 4; r++) begin
      int n;
      n = $urandom_range(1, KD);
      for (int i = 0; i < n; i++) begin
        c = 7'($urandom);
        q.push_back(c);
        kbd_send(c, ok);
        repeat ($urandom_range(0, 2)) @(negedge clk);
      end
      cpu_read(2'd1, d, s); nvec++;
      if (d !== 8'hA7) begin nerr++; $display("FAIL rk_cr: got %h want a7", d); end
      while (q.size() > 0) begin
        last = q.pop_front();
        cpu_read(2'd0, d, s); nvec++;
        if (d !== {1'b1, last}) begin nerr++; $display("FAIL rk_data: got %h want %h", d, {1'b1, last}); end
      end
      cpu_read(2'd0, d, s); nvec++;
      if (d !== {1'b0, last}) begin nerr++; $display("FAIL rk_idle: got %h want %h", d, {1'b0, last}); end
    end
  endtask

  task automatic test_back_to_back;
    bit ok;
    got.delete(); rdy_pulses = 0; ack_delay = 10; host_stall = 1'b0;
    @(negedge clk);
    AB = BASE | 16'd2; DO = 8'h48; WE = 1'b1; RDY = 1'b1;
    @(negedge clk);
    DO = 8'h49;
    @(negedge clk);
    AB = 16'h0000; DO = 8'h00; WE = 1'b0; RDY = 1'b0;
    nvec++;
    if ({dsp_rdy, dsp_data} !== {1'b1, 7'h48}) begin
      nerr++; $display("FAIL b2b_latency: got rdy=%b data=%h want 1 48", dsp_rdy, dsp_data);
    end
    wait_got(2, ok);
    repeat (4) @(negedge clk);
    nvec++;
    if (!ok || got.size() != 2) begin nerr++; $display("FAIL b2b_count: got %0d chars want 2", got.size()); end
    else begin
      nvec++;
      if (got[0] !== 7'h48 || got[1] !== 7'h49) begin
        nerr++; $display("FAIL b2b_data: got %h %h want 48 49", got[0], got[1]);
      end
    end
    nvec++;
    if (rdy_pulses != 2) begin nerr++; $display("FAIL b2b_pulses: got %0d want 2", rdy_pulses); end
  endtask

  // The holding register takes the first char, so the FIFO fills on write DD+1
  task automatic test_overflow;
    logic [7:0] d; logic s; bit ok;
    got.delete(); host_stall = 1'b1; ack_delay = 0;
    for (int i = 0; i <= DD + 1; i++) begin
      cpu_write(2'd2, 8'h50 + 8'(i));
      cpu_read(2'd2, d, s); nvec++;
      if (d !== {(i >= DD), 7'd0}) begin nerr++; $display("FAIL ovf_full%0d: got %h want %0d", i, d, (i >= DD)); end
      cpu_read(2'd3, d, s); nvec++;
      if (d !== {(i > DD), 7'h27}) begin nerr++; $display("FAIL ovf_flag%0d: got %h want %0d", i, d, (i > DD)); end
    end
    cpu_write(2'd3, 8'hA7);
    cpu_read(2'd3, d, s); nvec++;
    if (d !== 8'h27) begin nerr++; $display("FAIL ovf_clear: got %h want 27", d); end
    host_stall = 1'b0;
    wait_got(DD + 1, ok);
    repeat (10) @(negedge clk);
    nvec++;
    if (got.size() != DD + 1) begin nerr++; $display("FAIL ovf_count: got %0d want %0d", got.size(), DD + 1); end
    for (int i = 0; i < got.size() && i <= DD; i++) begin
      nvec++;
      if (got[i] !== 7'h50 + 7'(i)) begin nerr++; $display("FAIL ovf_order%0d: got %h want %h", i, got[i], 7'h50 + 7'(i)); end
    end
  endtask

  task automatic test_dsp_random;
    logic [7:0] d; logic s; bit ok;
    logic [6:0] q[$];
    for (int r = 0; r < 4; r++) begin
      int m;
      got.delete(); q.delete();
      m = $urandom_range(1, DD + 1);
      ack_delay = $urandom_range(0, 6);
      for (int i = 0; i < m; i++) begin
        logic [6:0] c;
        c = 7'($urandom);
        q.push_back(c);
        cpu_write(2'd2, {1'b0, c});
        repeat ($urandom_range(0, 3)) @(negedge clk);
      end
      wait_got(m, ok);
      nvec++;
      if (!ok) begin nerr++; $display("FAIL rd_timeout: got %0d chars want %0d", got.size(), m); end
      for (int i = 0; i < got.size() && i < m; i++) begin
        nvec++;
        if (got[i] !== q[i]) begin nerr++; $display("FAIL rd_data%0d: got %h want %h", i, got[i], q[i]); end
      end
      cpu_read(2'd3, d, s); nvec++;
      if (d !== 8'h27) begin nerr++; $display("FAIL rd_noovf: got %h want 27", d); end
    end
  endtask

  task automatic test_reset_mid;
    logic [7:0] d; logic s; bit ok; bit seen;
    host_stall = 1'b1; got.delete();
    kbd_send(7'h11, ok);
    kbd_send(7'h22, ok);
    cpu_write(2'd2, 8'h61);
    cpu_write(2'd2, 8'h62);
    cpu_write(2'd2, 8'h63);
    cpu_read(2'd3, d, s);
    kbd_data = 7'h33; kbd_rdy = 1'b1; ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin @(negedge clk); if (kbd_ack) ok = 1'b1; end
    nvec++;
    if ({ok, dsp_rdy} !== 2'b11) begin nerr++; $display("FAIL mid_setup: got ack=%b rdy=%b want 1 1", ok, dsp_rdy); end
    reset = 1'b1; kbd_rdy = 1'b0;
    @(negedge clk);
    nvec++;
    if ({pia_DI, pia_sel, kbd_ack, dsp_rdy, dsp_data} !== 18'd0) begin
      nerr++;
      $display("FAIL mid_reset: got DI=%h sel=%b ack=%b rdy=%b data=%h want all 0",
               pia_DI, pia_sel, kbd_ack, dsp_rdy, dsp_data);
    end
    reset = 1'b0; host_stall = 1'b0;
    seen = 1'b0;
    repeat (10) begin @(negedge clk); if (dsp_rdy) seen = 1'b1; end
    nvec++;
    if (seen) begin nerr++; $display("FAIL mid_dsp_empty: got rdy after reset want none"); end
    cpu_write(2'd1, 8'hA7);
    cpu_write(2'd3, 8'hA7);
    cpu_read(2'd1, d, s); nvec++;
    if (d !== 8'h27) begin nerr++; $display("FAIL mid_kbd_empty: got %h want 27", d); end
    cpu_read(2'd0, d, s); nvec++;
    if (d !== 8'h00) begin nerr++; $display("FAIL mid_kbd_last: got %h want 00", d); end
    cpu_read(2'd2, d, s); nvec++;
    if (d !== 8'h00) begin nerr++; $display("FAIL mid_dsp_full: got %h want 00", d); end
  endtask

  initial begin
    test_reset();
    test_init();
    test_kbd_single();
    test_kbd_backpressure();
    test_kbd_random();
    test_back_to_back();
    test_overflow();
    test_dsp_random();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no completion want finish");
    $fatal(1);
  end

endmodule
